cache_port_arbiter: RTL
=======================

// Module: cache_port_arbiter
// PURPOSE
// - Shares the single CPU-side port of cache_system between two requesters (port 0, port 1).
// - Round-robin arbitration; one cache access in flight at a time.
// - Drives cpu_read/cpu_write/cpu_address/cpu_wdata into the cache, holds them until ready.
// - Returns the 8-bit read data and a one-cycle done pulse to the owning requester.
// PARAMETERS
// - ADDR_W          32  address width, both requesters and cache
// - DATA_W          32  write-data width
// - RDATA_W         8   read-data width, matches cache cpu_data_out
// - TIMEOUT_CYCLES  64  watchdog limit in WAIT, used only with CACHE_ARB_TIMEOUT_EN
// PORTS
// - clk          in   1        clock, all state on rising edge
// - rst          in   1        asynchronous, active-high reset
// - reqN_valid   in   1        N=0,1: request pending; held with stable fields until reqN_done
// - reqN_we      in   1        1 = write, 0 = read
// - reqN_addr    in   ADDR_W   request address
// - reqN_wdata   in   DATA_W   write data, ignored for reads
// - reqN_rdata   out  RDATA_W  read data, valid in the reqN_done cycle and held after
// - reqN_done    out  1        one-cycle completion pulse
// - reqN_err     out  1        one-cycle abort pulse (timeout build only, else tied 0)
// - cache_read   out  1        to cache cpu_read
// - cache_write  out  1        to cache cpu_write
// - cache_addr   out  ADDR_W   to cache cpu_address
// - cache_wdata  out  DATA_W   to cache cpu_wdata
// - cache_rdata  in   RDATA_W  from cache cpu_data_out
// - cache_ready  in   1        from cache ready
// - busy         out  1        1 in any state except IDLE
// - owner        out  1        requester currently or last granted
// BEHAVIOUR
// - All outputs are registered. Reset: every output 0; state=IDLE; last-served pointer=1, so port 0 wins first.
// - FSM IDLE -> WAIT -> RELEASE -> IDLE.
// - IDLE, edge with any valid:
//   - Grant the port that has valid set. If both are valid, grant the port not equal to the last-served pointer.
//   - Latch owner. Drive cache_addr/wdata from that port.
//   - Set cache_write=we and cache_read=~we. Go to WAIT.
// - WAIT, edge with cache_ready=1:
//   - Capture cache_rdata into reqN_rdata (reads only; writes leave rdata unchanged).
//   - Pulse reqN_done for the owner. Clear cache_read/cache_write.
//   - Update the last-served pointer to owner. Go to RELEASE.
// - WAIT, cache_ready=0: hold all cache outputs unchanged.
// - RELEASE: exactly one cycle with the cache command low. valid inputs are ignored. Next edge goes to IDLE.
// - Requester rule: drop valid, or present a new request, in the cycle after done. The arbiter never re-samples the same request.
// - Latency: valid to done is at least 2 edges, when ready is seen at the first WAIT edge. Back-to-back grant spacing is at least 3 cycles.
// - cache_read and cache_write are never both 1. The non-owner's outputs never change during another port's access.
// - A request arriving during WAIT or RELEASE waits; the round-robin rule guarantees it is served next.
// - cache_ready seen high in IDLE or RELEASE is ignored.
// - rst mid-access drops the cache command immediately. The abandoned access gets no done.
// CONFIGURATION
// - CACHE_ARB_TIMEOUT_EN defined:
//   - A counter runs in WAIT, cleared on entry.
//   - If it reaches TIMEOUT_CYCLES with no ready: pulse reqN_err (not done), clear the command, go to RELEASE.
//   - The pointer still advances to owner.
// - CACHE_ARB_TIMEOUT_EN not defined: no counter; WAIT lasts indefinitely; reqN_err tied 0.
// TESTING
// - Reset: all outputs 0, busy=0; after release, idle with no valid -> cache_read=cache_write=0.
// - Port0 write 0x20=0xAAAAAAAA, then read 0x20 -> req0_rdata=0xAA, one done pulse each, owner=0.
// - req0 and req1 raised on the same edge (write 0x40=0x55555555, write 0x60=0xCAFEC0FF) -> port0 served first, then port1; reads return 0x55 and 0xFF.
// - Both ports continuously requesting -> grants alternate 0,1,0,1. The gap between done pulses is at least 3 cycles.
// - Cache model holding ready low 5 cycles -> cache_addr/cache_read stable throughout; done arrives on the edge after ready.
// - Timeout build with ready stuck low -> req_err after 64 WAIT cycles, no done; the other port is served next. Also assert rst mid-WAIT -> command drops immediately, no done.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter_if
// Bundle of every non-clock signal of cache_port_arbiter: two requester
// ports, the CPU-side command/response port of the cache, and status.
//
// Signals
//   reqN_valid/we/addr/wdata   requester -> arbiter (N = 0, 1)
//   reqN_rdata/done/err        arbiter -> requester
//   cache_read/write/addr/wdata arbiter -> cache
//   cache_rdata/ready          cache -> arbiter
//   busy, owner                arbiter status
//
// Modports
//   master : the arbiter's view (drives cache command and requester replies)
//   slave  : the environment's view (requesters plus cache)
// ---------------------------------------------------------------------------
interface cache_port_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RDATA_W = 8
);
    logic               req0_valid;
    logic               req0_we;
    logic [ADDR_W-1:0]  req0_addr;
    logic [DATA_W-1:0]  req0_wdata;
    logic [RDATA_W-1:0] req0_rdata;
    logic               req0_done;
    logic               req0_err;

    logic               req1_valid;
    logic               req1_we;
    logic [ADDR_W-1:0]  req1_addr;
    logic [DATA_W-1:0]  req1_wdata;
    logic [RDATA_W-1:0] req1_rdata;
    logic               req1_done;
    logic               req1_err;

    logic               cache_read;
    logic               cache_write;
    logic [ADDR_W-1:0]  cache_addr;
    logic [DATA_W-1:0]  cache_wdata;
    logic [RDATA_W-1:0] cache_rdata;
    logic               cache_ready;

    logic               busy;
    logic               owner;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  cache_rdata, cache_ready,
        output req0_rdata, req0_done, req0_err,
        output req1_rdata, req1_done, req1_err,
        output cache_read, cache_write, cache_addr, cache_wdata,
        output busy, owner
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output cache_rdata, cache_ready,
        input  req0_rdata, req0_done, req0_err,
        input  req1_rdata, req1_done, req1_err,
        input  cache_read, cache_write, cache_addr, cache_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
// Shares the single CPU-side port of the cache between two requesters with
// round-robin arbitration and one access in flight at a time. The granted
// request is driven into the cache and held until ready; read data and a
// one-cycle done pulse go back to the owning requester.
//
// Ports
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : cache_port_arbiter_if.master (requesters, cache port, busy/owner)
//
// Build option
//   CACHE_ARB_TIMEOUT_EN : when defined, a WAIT watchdog aborts an access
//   after TIMEOUT_CYCLES edges without ready and pulses reqN_err instead of
//   reqN_done. When undefined, WAIT lasts indefinitely and reqN_err is 0.
//
// Every output is a register cleared by reset. The FSM runs
// IDLE -> WAIT -> RELEASE -> IDLE; RELEASE keeps the command low for one
// cycle so a requester can retire its request before the next grant.
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int RDATA_W        = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic               last_served;
    logic               owner_r;
    logic               busy_r;
    logic               read_r;
    logic               write_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic [RDATA_W-1:0] rdata0_r;
    logic [RDATA_W-1:0] rdata1_r;
    logic               done0_r;
    logic               done1_r;

    // Grant choice: a lone requester wins; on contention the port that was
    // not served last wins.
    logic               grant;
    logic               grant_we;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_wdata;

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_served;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
        grant_we    = grant ? bus.req1_we    : bus.req0_we;
        grant_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        grant_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             err0_r;
    logic             err1_r;
    logic             timeout_hit;

    // wait_cnt holds the number of WAIT edges already seen without ready, so
    // the edge that finds it at TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_served <= 1'b1;
            owner_r     <= 1'b0;
            busy_r      <= 1'b0;
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rdata0_r    <= '0;
            rdata1_r    <= '0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            err0_r      <= 1'b0;
            err1_r      <= 1'b0;
`endif
        end else begin
            done0_r <= 1'b0;
            done1_r <= 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
            err0_r  <= 1'b0;
            err1_r  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        owner_r <= grant;
                        addr_r  <= grant_addr;
                        wdata_r <= grant_wdata;
                        write_r <= grant_we;
                        read_r  <= ~grant_we;
                        busy_r  <= 1'b1;
                        state   <= S_WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                S_WAIT: begin
                    if (bus.cache_ready) begin
                        // Writes leave the requester's read data untouched.
                        if (owner_r) begin
                            done1_r <= 1'b1;
                            if (read_r) rdata1_r <= bus.cache_rdata;
                        end else begin
                            done0_r <= 1'b1;
                            if (read_r) rdata0_r <= bus.cache_rdata;
                        end
                        read_r      <= 1'b0;
                        write_r     <= 1'b0;
                        last_served <= owner_r;
                        state       <= S_RELEASE;
                    end
`ifdef CACHE_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        if (owner_r) err1_r <= 1'b1;
                        else         err0_r <= 1'b1;
                        read_r      <= 1'b0;
                        write_r     <= 1'b0;
                        last_served <= owner_r;
                        state       <= S_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_RELEASE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    busy_r  <= 1'b0;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cache_read  = read_r;
    assign bus.cache_write = write_r;
    assign bus.cache_addr  = addr_r;
    assign bus.cache_wdata = wdata_r;
    assign bus.req0_rdata  = rdata0_r;
    assign bus.req1_rdata  = rdata1_r;
    assign bus.req0_done   = done0_r;
    assign bus.req1_done   = done1_r;
    assign bus.busy        = busy_r;
    assign bus.owner       = owner_r;

`ifdef CACHE_ARB_TIMEOUT_EN
    assign bus.req0_err = err0_r;
    assign bus.req1_err = err1_r;
`else
    assign bus.req0_err = 1'b0;
    assign bus.req1_err = 1'b0;
`endif

endmodule
